// File: rtl/spi_slave_mw.sv
// -----------------------------------------------------------------------------
// spi_slave_mw -- multi-word SPI slave running entirely in the i_clk domain.
//
// SCK, SSEL_n and MOSI are oversampled through SYNC_STAGES-deep synchronisers;
// SCK edges are found by comparing the synchronised level with one further
// register stage. All four SPI modes are supported (mode captured at frame
// start), the word width and bit order are parameters, and frames may carry
// any number of words.
//
// Ports:
//   i_clk, i_rst       system clock, synchronous active-high reset
//   i_mode             {CPOL,CPHA}, captured when a frame starts
//   i_tx_data/valid    host write into the TX holding register
//   o_tx_ready         TX holding register empty
//   o_rx_data/valid    last complete received word + one-cycle strobe
//   o_tx_underrun      strobe: a word started with the holding register empty
//   o_frame_done/err   strobe at frame end; err = frame ended mid-word
//   o_idle, o_busy     FSM in IDLE / in SHIFT
//   o_miso             serial out, high-impedance while raw i_ssel_n is high
//   i_ssel_n, i_mosi, i_sck   asynchronous SPI inputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave_mw #(
    parameter int   DATA_BITS   = 16,
    parameter int   SYNC_STAGES = 2,
    parameter bit   LSB_FIRST   = 1'b0,
    parameter logic IDLE_FILL   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_tx_underrun,
    output logic                 o_frame_done,
    output logic                 o_frame_err,
    output logic                 o_idle,
    output logic                 o_busy,
    output logic                 o_miso,
    input  logic                 i_ssel_n,
    input  logic                 i_mosi,
    input  logic                 i_sck
);
    localparam int                   CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] FILL_WORD = {DATA_BITS{IDLE_FILL}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [SYNC_STAGES-1:0] sck_sync_r, ssel_sync_r, mosi_sync_r;
    logic                   sck_d_r, ssel_d_r;
    logic                   sck_s, ssel_s, mosi_s;
    logic [1:0]             mode_r;
    logic [DATA_BITS-1:0]   hold_r, tx_sh_r, rx_sh_r, rx_data_r;
    logic                   tx_ready_r, reload_pend_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   rx_valid_r, underrun_r, done_r, err_r, idle_r, busy_r;
    logic                   lead_s, trail_s, sample_s, shift_edge_s, ssel_fall_s, load_s;

    // Next TX shifter value after presenting one bit; vacated position takes the fill bit.
    function automatic logic [DATA_BITS-1:0] shift_out(input logic [DATA_BITS-1:0] w);
        if (LSB_FIRST) begin
            return {IDLE_FILL, w[DATA_BITS-1:1]};
        end else begin
            return {w[DATA_BITS-2:0], IDLE_FILL};
        end
    endfunction

    // Next RX shifter value with one received bit appended in wire order.
    function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] w,
                                                      input logic b);
        if (LSB_FIRST) begin
            return {b, w[DATA_BITS-1:1]};
        end else begin
            return {w[DATA_BITS-2:0], b};
        end
    endfunction

    assign sck_s  = sck_sync_r[SYNC_STAGES-1];
    assign ssel_s = ssel_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Leading edge leaves the idle level CPOL, trailing edge returns to it.
    assign lead_s       = (sck_d_r == mode_r[1]) && (sck_s != mode_r[1]);
    assign trail_s      = (sck_d_r != mode_r[1]) && (sck_s == mode_r[1]);
    assign sample_s     = mode_r[0] ? trail_s : lead_s;
    assign shift_edge_s = mode_r[0] ? lead_s : trail_s;
    assign ssel_fall_s  = ssel_d_r & ~ssel_s;

    // Input synchronisers plus the extra edge-detect stage on SCK and SSEL.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sync_r  <= {SYNC_STAGES{1'b1}};
            ssel_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_d_r     <= 1'b1;
            ssel_d_r    <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], i_sck};
            ssel_sync_r <= {ssel_sync_r[SYNC_STAGES-2:0], i_ssel_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_mosi};
            sck_d_r     <= sck_s;
            ssel_d_r    <= ssel_s;
        end
    end

    // FSM next state; SHIFT leaves on the SSEL level so a deselect during LOAD is not missed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (ssel_fall_s) state_s = ST_LOAD; else state_s = ST_IDLE;
            ST_LOAD:  state_s = ST_SHIFT;
            ST_SHIFT: if (ssel_s) state_s = ST_IDLE; else state_s = ST_SHIFT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Word load request: at LOAD for CPHA=0, else on the first shift edge after a word boundary.
    always_comb begin
        load_s = 1'b0;
        if (state_r == ST_LOAD) begin
            load_s = ~mode_r[0];
        end else if (state_r == ST_SHIFT) begin
            load_s = ~ssel_s & shift_edge_s & reload_pend_r;
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM state register and registered state flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idle_r  <= (state_s == ST_IDLE);
            busy_r  <= (state_s == ST_SHIFT);
        end
    end

    // TX holding register, shifters, bit counter and host-side strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_r        <= 2'b00;
            hold_r        <= {DATA_BITS{1'b0}};
            tx_ready_r    <= 1'b1;
            tx_sh_r       <= {DATA_BITS{1'b0}};
            rx_sh_r       <= {DATA_BITS{1'b0}};
            rx_data_r     <= {DATA_BITS{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            reload_pend_r <= 1'b0;
            rx_valid_r    <= 1'b0;
            underrun_r    <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;

            // A write needs an empty holding register and a consume needs a full one,
            // so a write coinciding with a load always lands in the holding register.
            if (i_tx_valid && tx_ready_r) begin
                hold_r     <= i_tx_data;
                tx_ready_r <= 1'b0;
            end else if (load_s && !tx_ready_r) begin
                tx_ready_r <= 1'b1;
            end

            if (load_s) begin
                if (!tx_ready_r) begin
                    tx_sh_r <= hold_r;
                end else begin
                    tx_sh_r    <= FILL_WORD;
                    underrun_r <= 1'b1;
                end
            end else if (state_r == ST_SHIFT && !ssel_s && shift_edge_s) begin
                tx_sh_r <= shift_out(tx_sh_r);
            end

            case (state_r)
                ST_IDLE: begin
                    if (ssel_fall_s) mode_r <= i_mode;
                end
                ST_LOAD: begin
                    cnt_r         <= {CNT_W{1'b0}};
                    reload_pend_r <= mode_r[0];
                end
                ST_SHIFT: begin
                    if (ssel_s) begin
                        done_r        <= 1'b1;
                        err_r         <= (cnt_r != {CNT_W{1'b0}});
                        cnt_r         <= {CNT_W{1'b0}};
                        rx_sh_r       <= {DATA_BITS{1'b0}};
                        reload_pend_r <= 1'b0;
                    end else begin
                        if (sample_s) begin
                            rx_sh_r <= shift_in(rx_sh_r, mosi_s);
                            if (cnt_r == CNT_LAST) begin
                                cnt_r         <= {CNT_W{1'b0}};
                                rx_data_r     <= shift_in(rx_sh_r, mosi_s);
                                rx_valid_r    <= 1'b1;
                                reload_pend_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                        if (shift_edge_s && reload_pend_r) reload_pend_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign o_tx_ready    = tx_ready_r;
    assign o_rx_data     = rx_data_r;
    assign o_rx_valid    = rx_valid_r;
    assign o_tx_underrun = underrun_r;
    assign o_frame_done  = done_r;
    assign o_frame_err   = err_r;
    assign o_idle        = idle_r;
    assign o_busy        = busy_r;
    // MISO follows the raw select so the first bit is driven before synchronisation settles.
    assign o_miso        = i_ssel_n ? 1'bz
                         : (LSB_FIRST ? tx_sh_r[0] : tx_sh_r[DATA_BITS-1]);

endmodule

// File: tb/tb_spi_slave_mw.sv
`timescale 1ns/1ps
module tb_spi_slave_mw;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ssel_n, mosi, sck;
    logic [1:0] mode;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, underrun, fdone, ferr, idle, busy, miso;
    logic [7:0] l_tx_data, l_rx_data;
    logic       l_tx_valid, l_tx_ready, l_rx_valid, l_underrun, l_fdone, l_ferr;
    logic       l_idle, l_busy, l_miso;

    int         n_checks = 0;
    int         n_errors = 0;
    int         und_cnt  = 0;
    logic [7:0] feed_q[$], tx_model[$], rx_exp_q[$], miso_exp[$], mosi_words[$];
    logic       frame_exp_q[$];
    logic [7:0] lsb_word;

    spi_slave_mw #(.DATA_BITS(8), .SYNC_STAGES(2), .LSB_FIRST(1'b0), .IDLE_FILL(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .o_tx_underrun(underrun), .o_frame_done(fdone), .o_frame_err(ferr),
        .o_idle(idle), .o_busy(busy), .o_miso(miso),
        .i_ssel_n(ssel_n), .i_mosi(mosi), .i_sck(sck));

    spi_slave_mw #(.DATA_BITS(8), .SYNC_STAGES(2), .LSB_FIRST(1'b1), .IDLE_FILL(1'b1)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tx_data(l_tx_data), .i_tx_valid(l_tx_valid),
        .o_tx_ready(l_tx_ready), .o_rx_data(l_rx_data), .o_rx_valid(l_rx_valid),
        .o_tx_underrun(l_underrun), .o_frame_done(l_fdone), .o_frame_err(l_ferr),
        .o_idle(l_idle), .o_busy(l_busy), .o_miso(l_miso),
        .i_ssel_n(ssel_n), .i_mosi(mosi), .i_sck(sck));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic push_tx(input logic [7:0] v);
        feed_q.push_back(v);
        tx_model.push_back(v);
    endtask

    // Host-side feeder: writes queued words whenever the holding register is empty.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0 && tx_ready === 1'b1 && rst === 1'b0) begin
                tx_data  = feed_q.pop_front();
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expected RX words and frame results as the DUT strobes them.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rx_exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
        if (fdone === 1'b1) begin
            if (frame_exp_q.size() == 0) check("frame_done_unexpected", 32'(fdone), 32'd0);
            else check("frame_err", 32'(ferr), 32'(frame_exp_q.pop_front()));
        end
        if (underrun === 1'b1) und_cnt++;
    end

    // Master: nw full words then pbits of a partial word from mosi_words (MSB first).
    task automatic run_frame(input logic [1:0] fm, input int nw, input int pbits);
        logic       cpol, cpha, mb;
        int         loads, und_exp, und0, nbits, idx;
        logic [7:0] mw, lw, cur;
        cpol = fm[1];
        cpha = fm[0];
        // Each word start consumes one holding word; with CPHA=0 one more load
        // happens on the final trailing edge of every completed word.
        loads   = cpha ? nw + ((pbits > 0) ? 1 : 0) : nw + 1;
        und_exp = 0;
        miso_exp.delete();
        for (int i = 0; i < loads; i++) begin
            if (tx_model.size() > 0) miso_exp.push_back(tx_model.pop_front());
            else begin
                miso_exp.push_back(8'hFF);
                und_exp++;
            end
        end
        for (int i = 0; i < nw; i++) rx_exp_q.push_back(mosi_words[i]);
        frame_exp_q.push_back(pbits > 0);
        repeat (4) @(negedge clk);
        mode = fm;
        sck  = cpol;
        repeat (4) @(negedge clk);
        und0   = und_cnt;
        ssel_n = 1'b0;
        repeat (6) @(negedge clk);
        mode  = 2'($urandom_range(0, 3));
        nbits = nw * 8 + pbits;
        mw    = 8'h00;
        lw    = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            cur = mosi_words[b / 8];
            mb  = cur[7 - (b % 8)];
            if (!cpha) begin
                mosi = mb;
                repeat (HALF) @(negedge clk);
                mw  = {mw[6:0], miso};
                lw  = {lw[6:0], l_miso};
                sck = ~cpol;
                repeat (HALF) @(negedge clk);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mb;
                repeat (HALF) @(negedge clk);
                mw  = {mw[6:0], miso};
                lw  = {lw[6:0], l_miso};
                sck = cpol;
                repeat (HALF) @(negedge clk);
            end
            if (b % 8 == 7) begin
                idx = b / 8;
                check($sformatf("miso_word%0d", idx), 32'(mw), 32'(miso_exp[idx]));
                if (idx == 0) lsb_word = lw;
            end
        end
        repeat (HALF) @(negedge clk);
        ssel_n = 1'b1;
        mosi   = 1'b0;
        repeat (10) @(negedge clk);
        check("underrun_count", 32'(und_cnt - und0), 32'(und_exp));
    endtask

    task automatic set_mosi(input int n);
        mosi_words.delete();
        for (int i = 0; i < n; i++) mosi_words.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int nw, pb, ntx;
        logic [1:0] fm;
        rst = 1'b1; mode = 2'd0; ssel_n = 1'b1; mosi = 1'b0; sck = 1'b0;
        l_tx_valid = 1'b0; l_tx_data = 8'h00; lsb_word = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_strobes", 32'({rx_valid, underrun, fdone}), 32'd0);

        // Mode 0, preloaded 0xA5 out, 0x3C in.
        push_tx(8'hA5);
        mosi_words.delete(); mosi_words.push_back(8'h3C);
        run_frame(2'd0, 1, 0);

        // Mode 3, three-word frame.
        push_tx(8'h12); push_tx(8'h34); push_tx(8'h56);
        set_mosi(3);
        run_frame(2'd3, 3, 0);

        // Modes 1 and 2 with 0x81 both ways.
        push_tx(8'h81);
        mosi_words.delete(); mosi_words.push_back(8'h81);
        run_frame(2'd1, 1, 0);
        push_tx(8'h81);
        run_frame(2'd2, 1, 0);

        // Underrun: two words clocked, one supplied.
        push_tx(8'($urandom_range(0, 255)));
        set_mosi(2);
        run_frame(2'd1, 2, 0);

        // Abort after 5 bits, then a normal frame.
        push_tx(8'($urandom_range(0, 255)));
        set_mosi(1);
        run_frame(2'd0, 0, 5);
        push_tx(8'($urandom_range(0, 255)));
        set_mosi(1);
        run_frame(2'd0, 1, 0);

        // Reset in the middle of a word (holding register already empty).
        mode = 2'd0; sck = 1'b0;
        repeat (4) @(negedge clk);
        ssel_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; ssel_n = 1'b1; mosi = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_idle", 32'(idle), 32'd1);
        check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        push_tx(8'($urandom_range(0, 255)));
        set_mosi(1);
        run_frame(2'd2, 1, 0);

        // Randomised frames.
        for (int f = 0; f < 8; f++) begin
            fm  = 2'($urandom_range(0, 3));
            nw  = $urandom_range(1, 3);
            pb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            ntx = $urandom_range(0, nw + 1);
            for (int i = 0; i < ntx; i++) push_tx(8'($urandom_range(0, 255)));
            set_mosi(nw + 1);
            run_frame(fm, nw, pb);
        end

        // LSB-first instance: preload 0x01, first MISO bit must be 1.
        check("lsb_tx_ready", 32'(l_tx_ready), 32'd1);
        @(negedge clk);
        l_tx_data = 8'h01; l_tx_valid = 1'b1;
        @(negedge clk);
        l_tx_valid = 1'b0;
        push_tx(8'h5A);
        mosi_words.delete(); mosi_words.push_back(8'h35);
        run_frame(2'd0, 1, 0);
        check("lsb_first_bit", 32'(lsb_word[7]), 32'd1);
        check("lsb_miso_word", 32'(lsb_word), 32'(bitrev(8'h01)));
        check("lsb_rx_data", 32'(l_rx_data), 32'(bitrev(8'h35)));

        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frame_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_mw.md
Name: spi_slave_mw

Overview:
- Next-generation SPI slave for the CPLD design.
- Runs entirely in the i_clk domain: SCK, SSEL_n and MOSI are oversampled through synchronisers.
- Supports all four SPI modes, selected at run time, with a parametrised word width and bit order.
- Frames may carry any number of words, with valid/ready TX flow control, per-word RX strobes and underrun/framing error reporting toward the host-side logic.

Parameters:
DATA_BITS, 16, bits per SPI word (range 4..32)
SYNC_STAGES, 2, synchroniser flops on i_sck, i_ssel_n and i_mosi (range 2..3)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first (both TX and RX)
IDLE_FILL, 1'b1, bit value replicated to fill a word sent on TX underrun

Ports:
i_clk  in  1  system clock, must be at least 8x f_SCK
i_rst  in  1  synchronous reset, active-high
i_mode  in  2  {CPOL,CPHA}, captured at frame start only
i_tx_data  in  DATA_BITS  next word to transmit
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  TX holding register empty
o_rx_data  out  DATA_BITS  last complete received word
o_rx_valid  out  1  one-cycle strobe, o_rx_data updated
o_tx_underrun  out  1  one-cycle strobe, word start with holding register empty
o_frame_done  out  1  one-cycle strobe at frame end
o_frame_err  out  1  valid with o_frame_done: frame ended mid-word
o_idle  out  1  FSM in IDLE
o_busy  out  1  FSM in SHIFT
o_miso  out  1  MISO; 'z while raw i_ssel_n=1
i_ssel_n  in  1  slave select, active-low (async)
i_mosi  in  1  MOSI (async)
i_sck  in  1  SPI clock (async)

Behaviour:
- Clock and reset: one clock i_clk; reset is synchronous and active-high on i_rst.
- Reset values:
  - FSM = IDLE; all synchroniser flops = 1 except mosi = 0.
  - o_tx_ready = 1; o_rx_data = 0; all strobes = 0.
  - TX shifter = 0 and TX holding register empty; bit counter = 0; mode register = 0.
  - Reset mid-frame aborts the frame without asserting o_frame_done. The FSM stays in IDLE until it sees a new falling edge of synced SSEL.
- Synchronisation and edges:
  - sck_s, ssel_s and mosi_s are the outputs of SYNC_STAGES flops. A further register stage on sck_s provides edge detection.
  - Leading edge = sck_s leaving CPOL; trailing edge = sck_s returning to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- FSM states: IDLE -> LOAD -> SHIFT -> IDLE.
  - IDLE: on ssel_s falling, capture i_mode and go to LOAD.
  - LOAD (one cycle):
    - CPHA=0: load the shifter from the holding register, or the fill pattern, and set reload_pend=0.
    - CPHA=1: set reload_pend=1 and leave the shifter untouched.
    - Go to SHIFT.
  - SHIFT, on a sample edge:
    - Shift mosi_s into the RX shifter and increment cnt.
    - When cnt reaches DATA_BITS-1: the next cycle sets o_rx_data = assembled word and pulses o_rx_valid; cnt wraps to 0; reload_pend is set.
  - SHIFT, on a shift edge:
    - If reload_pend: load the next word and clear reload_pend.
    - Otherwise: shift TX one position (shift-in bit = IDLE_FILL).
  - SHIFT, on ssel_s rising: pulse o_frame_done, set o_frame_err = (cnt != 0), discard the partial RX word and go to IDLE. The leftover TX shifter contents are dropped.
- Word load rules:
  - If the holding register is full, it is consumed: o_tx_ready rises the next cycle.
  - If it is empty, the shifter is loaded with all IDLE_FILL bits and o_tx_underrun pulses.
  - A write (i_tx_valid && o_tx_ready) in the same cycle as a load goes to the holding register, not the shifter.
  - The holding register persists across frames, so the first word can be preloaded in IDLE.
- o_miso = shifter MSB (LSB if LSB_FIRST) whenever raw i_ssel_n=0, independent of FSM state.
- Timing constraint: the master must allow at least SYNC_STAGES+3 i_clk cycles from SSEL low to the first SCK edge.
- A mode change while a frame is active has no effect until the next frame.
- SCK edges seen in IDLE or LOAD are ignored.

Test Plan:
- DATA_BITS=8, mode 0: preload 0xA5; master sends 0x3C in one frame -> MISO bits 1,0,1,0,0,1,0,1; o_rx_valid once with o_rx_data=0x3C; o_frame_done=1 and o_frame_err=0.
- Mode 3, 3-word frame: TX 0x12, 0x34, 0x56 fed as o_tx_ready rises -> master receives 0x12,0x34,0x56; three o_rx_valid strobes with the MOSI words; no underrun.
- Modes 1 and 2 with word 0x81 each way -> correct sample/shift edges, data matches both directions.
- Underrun: 2-word frame, only one word supplied -> second MISO word 0xFF; o_tx_underrun exactly once.
- Abort: SSEL rises after 5 of 8 bits -> no o_rx_valid for the partial word; o_frame_done=1 with o_frame_err=1. The next frame receives correctly.
- i_rst asserted mid-word -> next cycle o_idle=1, o_tx_ready=1, o_rx_data=0; a subsequent full frame works. LSB_FIRST=1 run with 0x01 -> first MISO bit 1.
